enc_pipe: RTL

Pipelined SEC-DED encoder for the 128-bit datapath. It maps 128 data bits to the 137-bit codeword consumed by the decoder128 block: 8 Hamming check bits plus 1 overall parity bit. It sits on the write side of the protected store and uses a valid/ready handshake on both ports. It provides 2-cycle latency and full throughput, and keeps a saturating count of emitted words.

---
 rtl/ecc128_pkg.sv | 57 +++++
 rtl/ecc128_chk_gen.sv | 20 ++
 rtl/enc_pipe.sv | 83 ++++++++
 3 files changed

// File: rtl/ecc128_pkg.sv
// Shared SEC-DED definitions for the 128-bit datapath (encoder and decoder128).
// Codeword: out_cw[136:1] = Hamming positions 136..1, out_cw[0] = overall parity.
package ecc128_pkg;

   localparam int DATA_W = 128;
   localparam int CW_W   = 137;
   localparam int CHK_W  = 8;

   typedef logic [CW_W-1:0]            cw_t;
   typedef logic [CHK_W-1:0][CW_W-1:0] chk_mask_t;

   function automatic logic is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Hamming position of data bit i: the i-th non-power-of-two position from 3 upward.
   function automatic int data_pos(input int i);
      int j;
      int pos;
      j   = 0;
      pos = 0;
      for (int p = 1; p < CW_W; p++) begin
         if (!is_pow2(p)) begin
            if (j == i) pos = p;
            j++;
         end
      end
      return pos;
   endfunction

   function automatic cw_t place_data(input logic [DATA_W-1:0] d);
      cw_t cw;
      int  j;
      cw = '0;
      j  = 0;
      for (int p = 1; p < CW_W; p++) begin
         if (!is_pow2(p)) begin
            cw[p] = d[j];
            j++;
         end
      end
      return cw;
   endfunction

   function automatic chk_mask_t build_chk_masks();
      chk_mask_t m;
      m = '0;
      for (int k = 0; k < CHK_W; k++)
         for (int p = 1; p < CW_W; p++)
            m[k][p] = p[k];
      return m;
   endfunction

   // Bit p of CHK_MASK[k] is set when Hamming position p has bit k set.
   localparam chk_mask_t CHK_MASK = build_chk_masks();

endpackage

// File: rtl/ecc128_chk_gen.sv
// Combinational 128 -> 8 Hamming check-bit generator; the decoder reuses it for
// syndrome computation.
module ecc128_chk_gen
   import ecc128_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CHK_W-1:0]  chk
);

   cw_t placed;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      placed = place_data(data);
      chk    = '0;
      for (int k = 0; k < CHK_W; k++)
         chk[k] = ^(placed & CHK_MASK[k]);
   end

endmodule

// File: rtl/enc_pipe.sv
// Two-stage pipelined SEC-DED encoder, 128 data bits -> 137-bit codeword, with
// valid/ready on both ports. ENC_ERR_INJECT_EN adds the inj_mask error-injection port.
module enc_pipe
   import ecc128_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
`ifdef ENC_ERR_INJECT_EN
   input  logic [CW_W-1:0]   inj_mask,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   output logic [31:0]       word_cnt
);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CHK_W-1:0]  s1_chk;
   logic [CHK_W-1:0]  chk_nxt;
   logic              s2_load;
   logic              accept;
   cw_t               enc_cw;
`ifdef ENC_ERR_INJECT_EN
   cw_t               s1_mask;
`endif

   ecc128_chk_gen u_chk_gen (
      .data (in_data),
      .chk  (chk_nxt)
   );

   // Each stage loads when empty or when its contents leave this cycle.
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s2_load;
   assign accept   = in_valid & in_ready;

   always_comb begin
      enc_cw = place_data(s1_data);
      for (int k = 0; k < CHK_W; k++)
         enc_cw[1 << k] = s1_chk[k];
      enc_cw[0] = ^enc_cw[CW_W-1:1];
`ifdef ENC_ERR_INJECT_EN
      enc_cw = enc_cw ^ s1_mask;
`endif
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_cw    <= '0;
         word_cnt  <= '0;
      end else begin
         if (in_ready)
            s1_valid <= in_valid;
         if (s2_load) begin
            out_valid <= 1'b1;
            out_cw    <= enc_cw;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready && word_cnt != 32'hFFFF_FFFF)
            word_cnt <= word_cnt + 32'd1;
      end
   end

   // NOTE: S1 payload has no reset; it is only observed while s1_valid is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_data <= in_data;
         s1_chk  <= chk_nxt;
`ifdef ENC_ERR_INJECT_EN
         s1_mask <= inj_mask;
`endif
      end
   end

endmodule
